sipo_channel_scheduler: RTL and testbench

//  Sequences the shared serial-in/parallel-out ADC capture path across NUM_CH hydrophone channels.
//  On each sample-period tick it runs one frame:
//   - selects each enabled channel in ascending order;
//   - issues a start pulse to the SIPO capture controller and waits for its ready;
//   - latches the word into that channel's frame slot.

---
 rtl/sipo_channel_scheduler.sv | 136 +++++++++++++
 tb/tb_sipo_channel_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_channel_scheduler.sv
// Frame scheduler for a shared SIPO ADC capture path: on each sample tick it
// walks the enabled channels in ascending order, captures one word per channel and hands the frame downstream.
module sipo_channel_scheduler #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned TIMEOUT       = 64,
    localparam int unsigned CH_W         = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        chan_en,
    output logic                     sipo_start,
    input  logic                     sipo_ready,
    input  logic [DATA_W-1:0]        sipo_data,
    output logic [CH_W-1:0]          ch_sel,
    output logic [NUM_CH*DATA_W-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     busy,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic                     err_overrun,
    input  logic                     err_clr
);

    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, START, WAIT_RDY, NEXT, PRESENT
    } state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   per_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [NUM_CH-1:0]  mask_q;
    logic               tick, to_done, slot_wr, to_evt, ovr_evt;
    logic               first_hit, next_hit;
    logic [CH_W-1:0]    first_idx, next_idx;
    logic [NUM_CH-1:0]  to_set;

    assign tick    = enable && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign to_done = (to_cnt == TO_W'(TIMEOUT - 1));
    assign slot_wr = enable && (state_q == WAIT_RDY) && sipo_ready;
    assign to_evt  = enable && (state_q == WAIT_RDY) && !sipo_ready && to_done;
    assign ovr_evt = tick && (state_q != WAIT_TICK);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        to_set    = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (chan_en[i-1]) begin
                first_hit = 1'b1;
                first_idx = CH_W'(i - 1);
            end
            if (mask_q[i-1] && (CH_W'(i - 1) > ch_sel)) begin
                next_hit = 1'b1;
                next_idx = CH_W'(i - 1);
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++)
            to_set[k] = to_evt && (ch_sel == CH_W'(k));
    end

    always_comb begin
        state_d     = state_q;
        sipo_start  = 1'b0;
        frame_valid = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE:      if (enable) state_d = WAIT_TICK;
            WAIT_TICK: if (tick && first_hit) state_d = START;
            START: begin
                sipo_start = enable;
                busy       = 1'b1;
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: begin
                busy = 1'b1;
                if (sipo_ready || to_done) state_d = NEXT;
            end
            NEXT: begin
                busy    = 1'b1;
                state_d = next_hit ? START : PRESENT;
            end
            PRESENT: begin
                frame_valid = 1'b1;
                if (frame_ready) state_d = WAIT_TICK;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            per_cnt     <= '0;
            to_cnt      <= '0;
            mask_q      <= '0;
            ch_sel      <= '0;
            frame_data  <= '0;
            err_timeout <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (!enable || tick) per_cnt <= '0;
            else                 per_cnt <= per_cnt + 1'b1;

            if (state_q == START)         to_cnt <= '0;
            else if (state_q == WAIT_RDY) to_cnt <= to_cnt + 1'b1;

            if (state_q == WAIT_TICK && tick) mask_q <= chan_en;

            if (state_d == START)
                ch_sel <= (state_q == WAIT_TICK) ? first_idx : next_idx;

            for (int unsigned k = 0; k < NUM_CH; k++)
                if (slot_wr && (ch_sel == CH_W'(k)))
                    frame_data[k*DATA_W +: DATA_W] <= sipo_data;

            // A new event in the clear cycle keeps its flag set.
            err_timeout <= (err_timeout & ~{NUM_CH{err_clr}}) | to_set;
            err_overrun <= (err_overrun & ~err_clr) | ovr_evt;
        end
    end

endmodule

// File: tb/tb_sipo_channel_scheduler.sv
// Directed bench for sipo_channel_scheduler with a behavioural SIPO responder.
module tb_sipo_channel_scheduler;

    localparam int unsigned NUM_CH        = 4;
    localparam int unsigned DATA_W        = 12;
    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam int unsigned TIMEOUT       = 64;

    logic        clk = 1'b0;
    logic        reset_b, enable, sipo_start, sipo_ready, frame_valid, frame_ready;
    logic        busy, err_overrun, err_clr;
    logic [3:0]  chan_en, err_timeout;
    logic [11:0] sipo_data;
    logic [1:0]  ch_sel;
    logic [47:0] frame_data;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          last_rdy_cyc = 0;
    int          start_ch[$];
    int          rsp_delay = 12;
    logic [11:0] rsp_base = 12'hA00;
    logic [3:0]  mute = 4'b0000;
    logic        stray_req = 1'b0;

    sipo_channel_scheduler #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .enable(enable),
        .chan_en(chan_en),
        .sipo_start(sipo_start),
        .sipo_ready(sipo_ready),
        .sipo_data(sipo_data),
        .ch_sel(ch_sel),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int n = 0;
        while (frame_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_valid, 1);
    endtask

    task automatic wait_start(input string tag, input int ch, input int budget);
        int n = 0;
        while (!(sipo_start === 1'b1 && ch_sel == 2'(ch)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {sipo_start, ch_sel}, {1'b1, 2'(ch)});
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    // SIPO responder: answers rsp_delay cycles after a start unless muted.
    initial begin : sipo_model
        int pend;
        int pch;
        pend = 0;
        pch = 0;
        sipo_ready = 1'b0;
        sipo_data = '0;
        forever begin
            @(negedge clk);
            sipo_ready = 1'b0;
            if (stray_req) begin
                stray_req = 1'b0;
                sipo_ready = 1'b1;
                sipo_data = 12'hFFF;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sipo_ready = 1'b1;
                    sipo_data = rsp_base + 12'(pch);
                    last_rdy_cyc = cyc;
                end
            end
            if (sipo_start === 1'b1) begin
                start_ch.push_back(int'(ch_sel));
                if (!mute[ch_sel]) begin
                    pend = rsp_delay;
                    pch = int'(ch_sel);
                end
            end
        end
    end

    initial begin
        reset_b = 1'b0;
        enable = 1'b0;
        chan_en = 4'hF;
        frame_ready = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {sipo_start, frame_valid, busy, err_overrun, err_timeout, ch_sel}, 0);
        check("rst_data", frame_data, 0);
        reset_b = 1'b1;
        enable = 1'b1;

        // all four channels
        wait_frame("t1_frame", 400);
        check("t1_lat", cyc - last_rdy_cyc, 2);
        check("t1_nstart", start_ch.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_order%0d", i), start_ch[i], i);
        check("t1_data", frame_data, 48'hA03A02A01A00);
        repeat (5) @(negedge clk);
        check("t1_hold", {frame_valid, frame_data}, {1'b1, 48'hA03A02A01A00});
        check("t1_err", {err_overrun, err_timeout}, 0);
        accept();
        check("t1_accept", frame_valid, 0);

        // sparse mask, mid-frame mask change ignored
        chan_en = 4'b1010;
        rsp_base = 12'hB00;
        start_ch.delete();
        wait_start("t2_first", 1, 300);
        chan_en = 4'b0101;
        wait_frame("t2_frame", 200);
        check("t2_nstart", start_ch.size(), 2);
        check("t2_order0", start_ch[0], 1);
        check("t2_order1", start_ch[1], 3);
        check("t2_data", frame_data, 48'hB03A02B01A00);
        accept();

        // ch2 silent -> timeout
        chan_en = 4'hF;
        rsp_base = 12'hC00;
        mute = 4'b0100;
        start_ch.delete();
        wait_start("t3_ch2", 2, 300);
        repeat (64) @(negedge clk);
        check("t3_to_early", err_timeout, 0);
        @(negedge clk);
        check("t3_to_flag", err_timeout, 4'b0100);
        wait_frame("t3_frame", 200);
        check("t3_nstart", start_ch.size(), 4);
        check("t3_data", frame_data, 48'hC03A02C01C00);
        check("t3_sticky", err_timeout, 4'b0100);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_clr", err_timeout, 0);
        accept();
        mute = 4'b0000;

        // unaccepted frame across a tick -> overrun
        chan_en = 4'b0001;
        rsp_base = 12'hD00;
        start_ch.delete();
        wait_frame("t4_frame", 300);
        check("t4_ovr_pre", err_overrun, 0);
        repeat (210) @(negedge clk);
        check("t4_ovr", err_overrun, 1);
        check("t4_held", frame_valid, 1);
        check("t4_nstart", start_ch.size(), 1);
        accept();
        repeat (20) @(negedge clk);
        check("t4_nostart", start_ch.size(), 1);
        wait_start("t4_next", 0, 300);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_clr", err_overrun, 0);
        wait_frame("t4_frame2", 100);
        check("t4_data", frame_data, 48'hC03A02C01D00);
        accept();

        // ready on the timeout cycle wins; stray ready ignored
        rsp_delay = 64;
        rsp_base = 12'hE00;
        wait_frame("t5_frame", 400);
        check("t5_data", frame_data, 48'hC03A02C01E00);
        check("t5_noerr", err_timeout, 0);
        accept();
        rsp_delay = 12;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_stray", frame_data, 48'hC03A02C01E00);

        // enable drop mid-frame, then async reset mid-frame
        chan_en = 4'hF;
        rsp_base = 12'hF00;
        start_ch.delete();
        wait_start("t6_ch1", 1, 300);
        repeat (3) @(negedge clk);
        check("t6_busy_pre", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        check("t6_idle", {busy, frame_valid, sipo_start}, 0);
        repeat (30) @(negedge clk);
        check("t6_nostart", start_ch.size(), 2);
        check("t6_fv", frame_valid, 0);
        check("t6_data", frame_data, 48'hC03A02C01F00);
        enable = 1'b1;
        start_ch.delete();
        wait_start("t6_ch1b", 1, 400);
        repeat (2) @(negedge clk);
        check("t6_pre_rst", {busy, ch_sel}, {1'b1, 2'd1});
        #2 reset_b = 1'b0;
        #1;
        check("t6_rst_ctl", {sipo_start, frame_valid, busy, err_overrun, err_timeout, ch_sel}, 0);
        check("t6_rst_data", frame_data, 0);
        @(negedge clk);
        reset_b = 1'b1;
        start_ch.delete();
        repeat (150) @(negedge clk);
        check("t6_post_nostart", start_ch.size(), 0);
        check("t6_post_data", {busy, frame_data}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
